uart_id_responder: RTL
======================

// Module: uart_id_responder
// PURPOSE
//  UART command responder that replaces the RX->TX loopback on the board top level.
//  Receives 8N1 bytes on UART_RX. On the query byte '?' (8'h3F) it transmits the board
//  ID as one ASCII hex digit followed by CR LF. The host can then identify the board over serial.
//  Sits between the board UART pins and the BOARD_ID register driven by the top level.
// PARAMETERS
//  CLKS_PER_BIT  104   CLK cycles per UART bit (12 MHz / 115200); legal range >= 4
//  QUERY_CHAR    8'h3F command byte that triggers a reply
// PORTS
//  CLK       in   1  system clock; all logic on rising edge
//  RST       in   1  synchronous, active-high reset
//  UART_RX   in   1  asynchronous serial input, idle high
//  BOARD_ID  in   4  board ID; sampled only when a query is accepted
//  UART_TX   out  1  serial output, idle high; driven directly from a flop
//  BUSY      out  1  high while a reply is being transmitted
//  RX_ERR    out  1  1-cycle pulse: stop bit sampled low (framing error)
//  RX_DROP   out  1  1-cycle pulse: query received while BUSY, query discarded
// BEHAVIOUR
//  Reset values
//  - Reset: UART_TX=1, BUSY=0, RX_ERR=0, RX_DROP=0.
//  - Reset: both synchronizer flops=1, both FSMs idle, all counters=0.
//  - RST asserted mid-frame aborts RX and TX.
//  - After a mid-frame RST, UART_TX is 1 on the cycle after the RST edge.
//  RX path
//  - UART_RX passes through a 2-flop synchronizer; rxs is the second flop.
//  - RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
//  - R_IDLE: rxs==0 -> R_START, bit counter cleared.
//  - R_START: wait CLKS_PER_BIT/2 cycles (integer division), then sample rxs.
//    rxs==0 -> R_DATA; rxs==1 -> R_IDLE (glitch rejected, no error reported).
//  - R_DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first, shifted into rx_byte.
//    After the 8th sample -> R_STOP.
//  - R_STOP: sample once, CLKS_PER_BIT after the last data sample, then -> R_IDLE.
//    Sample==1: byte is valid; raise internal rx_valid for 1 cycle.
//    Sample==0: pulse RX_ERR and discard the byte. No resync wait; R_IDLE waits for the next falling rxs.
//  Command decode (in the rx_valid cycle)
//  - rx_byte==QUERY_CHAR and BUSY==0: latch BOARD_ID, load the reply, start TX.
//  - rx_byte==QUERY_CHAR and BUSY==1: pulse RX_DROP; TX unaffected.
//  - Any other byte: ignored silently.
//  - RX runs independently of TX; receiving during transmission is legal.
//  Reply content
//  - Byte 0: hex digit of the latched ID. ID 0-9 -> 8'h30+ID; ID 10-15 -> 8'h37+ID ('A'..'F').
//  - Byte 1: 8'h0D. Byte 2: 8'h0A.
//  - The latched ID is held for the whole reply; BOARD_ID changes mid-reply have no effect.
//  TX path
//  - TX FSM states: T_IDLE, T_START, T_DATA, T_STOP.
//  - Each state/bit lasts exactly CLKS_PER_BIT cycles.
//  - Data is LSB first; 1 stop bit; the 3 bytes go back-to-back with no idle gap.
//  - UART_TX goes low on the first CLK after the accept cycle.
//  - BUSY rises in that same cycle.
//  - BUSY falls in the cycle after byte 2's stop bit completes.
//  - Reply duration: 30*CLKS_PER_BIT cycles with BUSY==1.
//  - A new query is accepted in the first cycle with BUSY==0.
//  Arithmetic/width
//  - Baud counter width = $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1, never overflows.
//  - TX bit index 0..9; byte index 0..2.
// TESTING (bench uses CLKS_PER_BIT=8)
//  1 BOARD_ID=4'd5, send 8'h3F -> TX frames 8'h35,8'h0D,8'h0A.
//    BUSY high for exactly 240 cycles; RX_ERR=RX_DROP=0.
//  2 BOARD_ID=4'd12, send '?' -> first reply byte 8'h43 ('C').
//    Repeat for IDs 0, 9, 10, 15 -> 8'h30, 8'h39, 8'h41, 8'h46.
//  3 Send '?' then a second '?' immediately -> first reply intact.
//    One RX_DROP pulse at the second byte's stop sample; exactly 3 bytes transmitted.
//  4 Send 8'h3F with stop bit forced 0 -> one RX_ERR pulse, UART_TX stays 1, BUSY stays 0.
//    Then a clean '?' -> normal reply.
//  5 UART_RX low for 2 cycles only (glitch); send 8'h41 -> no reply, no RX_ERR.
//    Change BOARD_ID mid-reply -> reply digit unchanged.
//  6 Assert RST 1 cycle during byte 1 of a reply -> next cycle UART_TX=1, BUSY=0.
//    A following '?' produces a full correct reply.

Source files
------------

// File: rtl/uart_id_responder.sv
// uart_id_responder: answers a UART '?' query with the board ID as a hex digit plus CR LF
module uart_id_responder #(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] QUERY_CHAR   = 8'h3F
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RX,
    input  logic [3:0] BOARD_ID,
    output logic       UART_TX,
    output logic       BUSY,
    output logic       RX_ERR,
    output logic       RX_DROP
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HLAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    logic            rx_s1, rxs;
    rx_state_t       r, r_n;
    logic [CW-1:0]   rc, rc_n;
    logic [2:0]      rb, rb_n;
    logic [7:0]      rx_byte, rx_byte_n;
    logic            rx_valid, rx_valid_n, rx_err_n;
    tx_state_t       t, t_n;
    logic [CW-1:0]   tc, tc_n;
    logic [3:0]      tb, tb_n;
    logic [1:0]      ti, ti_n;
    logic [3:0]      id, id_n;
    logic            tx_n, drop_n, query;
    logic [7:0]      hex, cur;

    assign BUSY  = t != T_IDLE;
    assign query = rx_valid && rx_byte == QUERY_CHAR;
    assign hex   = id < 4'd10 ? 8'h30 + {4'h0, id} : 8'h37 + {4'h0, id};
    assign cur   = ti == 2'd0 ? hex : ti == 2'd1 ? 8'h0D : 8'h0A;

    // RX next state: mid-bit sampling of the synchronized line
    always_comb begin
        r_n        = r;
        rc_n       = rc == LAST ? '0 : rc + 1'b1;
        rb_n       = rb;
        rx_byte_n  = rx_byte;
        rx_valid_n = 1'b0;
        rx_err_n   = 1'b0;
        case (r)
            R_IDLE: begin
                rc_n = '0;
                rb_n = '0;
                if (!rxs) r_n = R_START;
            end
            R_START: if (rc == HLAST) begin
                rc_n = '0;
                r_n  = rxs ? R_IDLE : R_DATA;
            end
            R_DATA: if (rc == LAST) begin
                rx_byte_n = {rxs, rx_byte[7:1]};
                rb_n      = rb + 1'b1;
                if (rb == 3'd7) r_n = R_STOP;
            end
            default: if (rc == LAST) begin
                r_n        = R_IDLE;
                rx_valid_n = rxs;
                rx_err_n   = !rxs;
            end
        endcase
    end

    // TX next state: three back-to-back 8N1 frames from the latched ID
    always_comb begin
        t_n    = t;
        tc_n   = tc == LAST ? '0 : tc + 1'b1;
        tb_n   = tb;
        ti_n   = ti;
        id_n   = id;
        tx_n   = UART_TX;
        drop_n = query && BUSY;
        case (t)
            T_IDLE: begin
                tc_n = '0;
                tb_n = '0;
                ti_n = '0;
                if (query) begin
                    id_n = BOARD_ID;
                    t_n  = T_START;
                    tx_n = 1'b0;
                end
            end
            T_START: if (tc == LAST) begin
                t_n  = T_DATA;
                tb_n = 4'd1;
                tx_n = cur[0];
            end
            T_DATA: if (tc == LAST) begin
                tb_n = tb + 1'b1;
                t_n  = tb == 4'd8 ? T_STOP : T_DATA;
                tx_n = tb == 4'd8 ? 1'b1 : cur[tb[2:0]];
            end
            default: if (tc == LAST) begin
                tb_n = '0;
                ti_n = ti == 2'd2 ? ti : ti + 1'b1;
                t_n  = ti == 2'd2 ? T_IDLE : T_START;
                tx_n = ti == 2'd2;
            end
        endcase
    end

    // state registers, synchronizer and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_s1    <= 1'b1;
            rxs      <= 1'b1;
            r        <= R_IDLE;
            rc       <= '0;
            rb       <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            RX_ERR   <= 1'b0;
            t        <= T_IDLE;
            tc       <= '0;
            tb       <= '0;
            ti       <= '0;
            id       <= '0;
            UART_TX  <= 1'b1;
            RX_DROP  <= 1'b0;
        end else begin
            rx_s1    <= UART_RX;
            rxs      <= rx_s1;
            r        <= r_n;
            rc       <= rc_n;
            rb       <= rb_n;
            rx_byte  <= rx_byte_n;
            rx_valid <= rx_valid_n;
            RX_ERR   <= rx_err_n;
            t        <= t_n;
            tc       <= tc_n;
            tb       <= tb_n;
            ti       <= ti_n;
            id       <= id_n;
            UART_TX  <= tx_n;
            RX_DROP  <= drop_n;
        end
    end
endmodule
